dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/starve_timer.sv | 32 +++
 rtl/dmem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory port arbiter and its starvation timer.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned WAIT_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/starve_timer.sv
// Starvation wait counter: clear has priority over enable, and the count parks at
// MAX_WAIT so it can never wrap. o_terminal flags the limit.
module starve_timer
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CNT_W    = WAIT_CNT_W,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_terminal
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term     = (r_cnt == CNT_W'(MAX_WAIT));
    assign o_terminal = w_term;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_term) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory arbiter: the CPU owns the port, the debug reader gets idle
// cycles, and a starved debug request forces a one-cycle CPU stall.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                   sysclk,
    input  logic                   cpu_resetn,
    input  logic                   cpu_en,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [3:0]             cpu_wren,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_stall,
    input  logic                   dbg_req,
    input  logic [ADDR_W-1:0]      dbg_addr,
    output logic                   dbg_ack,
    output logic [31:0]            dbg_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [3:0]             mem_wren,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    output logic [STALL_CNT_W-1:0] stall_count
);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic                   w_grant_dbg;
    logic                   w_tmr_en;
    logic                   w_tmr_clr;
    logic                   w_tmr_term;
    logic                   r_dbg_ack;
    logic [31:0]            r_dbg_rdata;
    logic [STALL_CNT_W-1:0] r_stall_count;

    starve_timer #(
        .CNT_W    (WAIT_CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_timer (
        .i_clk      (sysclk),
        .i_rst_n    (cpu_resetn),
        .i_clr      (w_tmr_clr),
        .i_en       (w_tmr_en),
        .o_terminal (w_tmr_term)
    );

    // State register
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a dropped request abandons the wait without an ack
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (dbg_req && !cpu_en) begin
                    w_state_nxt = ACK;
                end else if (dbg_req) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!dbg_req) begin
                    w_state_nxt = IDLE;
                end else if (!cpu_en) begin
                    w_state_nxt = ACK;
                end else if (w_tmr_term) begin
                    w_state_nxt = FORCE;
                end
            end
            FORCE:   w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant decode, port mux and timer control
    always_comb begin
        w_grant_dbg = 1'b0;
        mem_addr    = cpu_addr;
        mem_wren    = 4'h0;
        mem_wdata   = cpu_wdata;
        w_tmr_en    = 1'b0;
        w_tmr_clr   = 1'b1;

        if (r_state == FORCE) begin
            w_grant_dbg = 1'b1;
        end else if ((r_state == IDLE || r_state == WAIT) && dbg_req && !cpu_en) begin
            w_grant_dbg = 1'b1;
        end

        if (w_grant_dbg) begin
            mem_addr = dbg_addr;
        end else if (cpu_en) begin
            mem_wren = cpu_wren;
        end

        // The counter runs only while the request keeps waiting; IDLE->WAIT loads 1
        if (w_state_nxt == WAIT) begin
            w_tmr_en  = 1'b1;
            w_tmr_clr = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            r_dbg_ack     <= 1'b0;
            r_dbg_rdata   <= '0;
            r_stall_count <= '0;
        end else begin
            r_dbg_ack <= (w_state_nxt == ACK);
            if (w_grant_dbg) begin
                r_dbg_rdata <= mem_rdata;
            end
            if (r_state == FORCE && r_stall_count != '1) begin
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
            end
        end
    end

    assign cpu_rdata   = mem_rdata;
    assign cpu_stall   = (r_state == FORCE);
    assign dbg_ack     = r_dbg_ack;
    assign dbg_rdata   = r_dbg_rdata;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_dmem_port_arbiter;

    localparam int unsigned MAXW = 15;

    logic        sysclk;
    logic        cpu_resetn;
    logic        cpu_en;
    logic [7:0]  cpu_addr;
    logic [3:0]  cpu_wren;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic [7:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] stall_count;

    dmem_port_arbiter #(.ADDR_W(8), .MAX_WAIT(MAXW)) dut (
        .sysclk      (sysclk),
        .cpu_resetn  (cpu_resetn),
        .cpu_en      (cpu_en),
        .cpu_addr    (cpu_addr),
        .cpu_wren    (cpu_wren),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall_count (stall_count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Physical memory driven by the DUT's port, and the bench's own expected contents
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    assign mem_rdata = mem[mem_addr];

    int total = 0;
    int bad   = 0;

    // Reference model: a debug request is either being acknowledged, being forced,
    // or has been refused for m_denied consecutive cycles.
    logic        m_ack;
    logic        m_force;
    int          m_denied;
    logic [15:0] m_stalls;
    logic [31:0] m_rdata;

    logic        s_stall, s_ack;
    logic [7:0]  s_maddr;
    logic [3:0]  s_wren;
    logic [31:0] s_drd;
    logic [15:0] s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ack    = 1'b0;
        m_force  = 1'b0;
        m_denied = 0;
        m_stalls = 16'h0;
        m_rdata  = 32'h0;
    endtask

    task automatic sample();
        s_stall = cpu_stall;
        s_ack   = dbg_ack;
        s_maddr = mem_addr;
        s_wren  = mem_wren;
        s_drd   = dbg_rdata;
        s_cnt   = stall_count;
    endtask

    // One clock cycle: drive, check at the falling edge, advance model, apply the write
    task automatic cycle(input logic en, input logic [7:0] ca, input logic [3:0] wr,
                         input logic [31:0] wd, input logic rq, input logic [7:0] da);
        logic        grant;
        logic [7:0]  e_addr;
        logic [3:0]  e_wren;
        logic [7:0]  w_a;
        logic [3:0]  w_e;
        logic [31:0] w_d;
        cpu_en = en; cpu_addr = ca; cpu_wren = wr; cpu_wdata = wd;
        dbg_req = rq; dbg_addr = da;
        @(negedge sysclk);
        grant  = m_force || (!m_ack && rq && !en);
        e_addr = grant ? da : ca;
        e_wren = (grant || !en) ? 4'h0 : wr;
        chk("cpu_stall",   32'(cpu_stall),   32'(m_force));
        chk("dbg_ack",     32'(dbg_ack),     32'(m_ack));
        chk("mem_addr",    32'(mem_addr),    32'(e_addr));
        chk("mem_wren",    32'(mem_wren),    32'(e_wren));
        chk("mem_wdata",   mem_wdata,        wd);
        chk("cpu_rdata",   cpu_rdata,        ref_mem[e_addr]);
        chk("dbg_rdata",   dbg_rdata,        m_rdata);
        chk("stall_count", 32'(stall_count), 32'(m_stalls));
        sample();
        w_a = mem_addr; w_e = mem_wren; w_d = mem_wdata;

        if (grant) begin
            m_rdata = ref_mem[da];
            if (m_force && m_stalls != 16'hFFFF) m_stalls = m_stalls + 16'd1;
            m_ack    = 1'b1;
            m_force  = 1'b0;
            m_denied = 0;
        end else if (m_ack) begin
            m_ack    = 1'b0;
            m_denied = 0;
        end else if (rq) begin
            m_denied++;
            if (m_denied == int'(MAXW) + 1) begin
                m_force  = 1'b1;
                m_denied = 0;
            end
        end else begin
            m_denied = 0;
        end
        for (int b = 0; b < 4; b++)
            if (e_wren[b]) ref_mem[e_addr][8*b +: 8] = wd[8*b +: 8];

        @(posedge sysclk);
        #1;
        for (int b = 0; b < 4; b++)
            if (w_e[b]) mem[w_a][8*b +: 8] = w_d[8*b +: 8];
    endtask

    // One cycle held in reset; arbitration state must read as cleared
    task automatic reset_cycle(input logic en, input logic rq, input logic [7:0] da);
        cpu_resetn = 1'b0;
        cpu_en = en; cpu_wren = 4'h0; dbg_req = rq; dbg_addr = da;
        @(negedge sysclk);
        chk("rst_stall",  32'(cpu_stall),   32'h0);
        chk("rst_ack",    32'(dbg_ack),     32'h0);
        chk("rst_count",  32'(stall_count), 32'h0);
        chk("rst_rdata",  dbg_rdata,        32'h0);
        model_reset();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        int          first_stall;
        int          first_ack;
        logic [5:0]  acks;
        logic [31:0] wd;
        logic        rq;
        logic [7:0]  da;
        int          pct;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h90] = 32'd97; ref_mem[8'h90] = 32'd97;
        model_reset();
        cpu_resetn = 1'b0; cpu_en = 1'b0; cpu_addr = 8'h0; cpu_wren = 4'h0;
        cpu_wdata = 32'h0; dbg_req = 1'b0; dbg_addr = 8'h0;
        @(posedge sysclk); #1;
        reset_cycle(1'b0, 1'b0, 8'h0);
        cpu_resetn = 1'b1;

        // Idle after reset: port follows the CPU address
        cycle(1'b0, 8'h3C, 4'h0, 32'h0, 1'b0, 8'h0);
        chk("idle_maddr", 32'(s_maddr), 32'h3C);
        chk("idle_ack",   32'(s_ack),   32'h0);

        // Free port: granted in the request cycle, acked the next
        cycle(1'b0, 8'h11, 4'h0, 32'h0, 1'b1, 8'h90);
        chk("free_maddr", 32'(s_maddr), 32'h90);
        cycle(1'b0, 8'h11, 4'h0, 32'h0, 1'b0, 8'h90);
        chk("free_ack",   32'(s_ack),   32'h1);
        chk("free_rdata", s_drd,        32'd97);

        // Contention: a CPU store to the requested word lands before the debug read
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h85, 4'hF, 32'h315, 1'b1, 8'h85);
            chk("cont_nostall", 32'(s_stall), 32'h0);
        end
        cycle(1'b0, 8'h85, 4'h0, 32'h0, 1'b1, 8'h85);
        chk("cont_maddr", 32'(s_maddr), 32'h85);
        cycle(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h85);
        chk("cont_ack",   32'(s_ack), 32'h1);
        chk("cont_rdata", s_drd,      32'h315);
        cycle(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);

        // Starvation: CPU busy every cycle, stall comes MAXW+1 cycles after the request
        first_stall = -1; first_ack = -1;
        wd = $urandom;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'h40, 4'hF, wd, 1'b1, 8'h85);
            if (s_stall && first_stall < 0) begin
                first_stall = i;
                chk("starve_wren", 32'(s_wren), 32'h0);
            end
            if (s_ack && first_ack < 0) begin
                first_ack = i;
                chk("starve_count", 32'(s_cnt), 32'h1);
            end
        end
        chk("starve_lat", 32'(first_stall), 32'(MAXW + 1));
        chk("starve_ack", 32'(first_ack),   32'(MAXW + 2));

        // Back-to-back requests with a free CPU: one ack every other cycle
        acks = 6'h0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h07, 4'h0, 32'h0, 1'b1, 8'(8'h90 + i / 2));
            acks[i] = s_ack;
        end
        chk("b2b_acks", 32'(acks), 32'h2A);
        cycle(1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00);

        // Reset while a request is waiting, then normal service after release
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h50, 4'h0, 32'h0, 1'b1, 8'h22);
        reset_cycle(1'b1, 1'b1, 8'h22);
        reset_cycle(1'b1, 1'b1, 8'h22);
        cpu_resetn = 1'b1;
        cycle(1'b0, 8'h50, 4'h0, 32'h0, 1'b1, 8'h22);
        cycle(1'b0, 8'h50, 4'h0, 32'h0, 1'b0, 8'h22);
        chk("rst_served_ack",   32'(s_ack), 32'h1);
        chk("rst_served_rdata", s_drd,      ref_mem[8'h22]);

        // Random traffic at varying CPU load
        rq = 1'b0; da = 8'h0;
        for (int blk = 0; blk < 9; blk++) begin
            pct = (blk % 3 == 0) ? 50 : ((blk % 3 == 1) ? 90 : 100);
            for (int i = 0; i < 60; i++) begin
                if (rq && s_ack) begin
                    rq = ($urandom_range(0, 1) == 1);
                    da = 8'($urandom);
                end else if (!rq) begin
                    rq = ($urandom_range(0, 99) < 30);
                    da = 8'($urandom);
                end else if ($urandom_range(0, 199) == 0) begin
                    rq = 1'b0;
                end
                cycle(($urandom_range(0, 99) < pct), 8'($urandom), 4'($urandom),
                      $urandom, rq, da);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
